// File: rtl/ls_unit.sv
// Load/store unit between the multicycle datapath and word-addressed data memory.
// Define LS_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them.
module ls_unit #(
   parameter int MEM_WORDS  = 5097,
   parameter int ACCESS_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] baddr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);
   localparam logic [3:0]  LAT_INIT   = 4'(ACCESS_LAT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

   state_t      state, state_next;
   logic [3:0]  cnt;
   logic        lat_we, lat_sext;
   logic [1:0]  lat_size;
   logic [31:0] lat_addr, lat_wdata;

   logic [31:0] aligned_addr;
   logic        misalign, bad_req, last;
   logic [1:0]  off;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_v;

   // Request screening: alignment handling depends on the trap build option.
   always_comb begin
      aligned_addr = baddr;
      misalign     = 1'b0;
`ifdef LS_MISALIGN_TRAP_EN
      misalign = ((size == 2'b01) && baddr[0]) ||
                 ((size == 2'b10) && (baddr[1:0] != 2'b00));
`else
      if (size == 2'b01) aligned_addr[0] = 1'b0;
      if (size == 2'b10) aligned_addr[1:0] = 2'b00;
`endif
      bad_req = (size == 2'b11) || ({2'b00, baddr[31:2]} >= WORD_LIMIT) || misalign;
   end

   assign last = (cnt == 4'd0);
   assign off  = lat_addr[1:0];

   always_comb begin
      byte_v = mem_dout[{off, 3'b000} +: 8];
      half_v = mem_dout[{off[1], 4'b0000} +: 16];
      case (lat_size)
         2'b00:   load_v = {{24{lat_sext & byte_v[7]}}, byte_v};
         2'b01:   load_v = {{16{lat_sext & half_v[15]}}, half_v};
         default: load_v = mem_dout;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Strobes are decoded from the registered state so reset removes mem_we at once.
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      mem_we     = 1'b0;
      mem_be     = 4'b0000;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (req) state_next = bad_req ? ERR : ACCESS;
         end
         ACCESS: begin
            mem_we = lat_we & last;
            case (lat_size)
               2'b00:   mem_be = 4'b0001 << off;
               2'b01:   mem_be = off[1] ? 4'b1100 : 4'b0011;
               default: mem_be = 4'b1111;
            endcase
            if (last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         ERR: begin
            done       = 1'b1;
            err        = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= 4'd0;
         lat_we    <= 1'b0;
         lat_sext  <= 1'b0;
         lat_size  <= 2'b00;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         rdata     <= 32'd0;
      end else begin
         if (state == IDLE && req) begin
            cnt       <= LAT_INIT;
            lat_we    <= we;
            lat_sext  <= sext;
            lat_size  <= size;
            lat_addr  <= aligned_addr;
            lat_wdata <= wdata;
         end else if (state == ACCESS) begin
            if (!last) cnt <= cnt - 4'd1;
            else if (!lat_we) rdata <= load_v;
         end
      end
   end

   assign mem_addr = {2'b00, lat_addr[31:2]};
   assign mem_din  = lat_wdata;

endmodule

// File: tb/tb_ls_unit.sv
// Self-checking bench for ls_unit: vector table with scoreboard plus hand-written corner sequences.
// Expectations follow LS_MISALIGN_TRAP_EN when the bench is built with it.
module tb_ls_unit;

   localparam int MEMW = 5097;

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] baddr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_addr;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst3, req, req3, we, sext;
   logic [1:0]  size;
   logic [31:0] baddr, wdata;
   logic        ready, done, err, mem_we;
   logic [31:0] rdata, mem_addr, mem_din, mem_dout;
   logic [3:0]  mem_be;
   logic        ready3, done3, err3, mem_we3;
   logic [31:0] rdata3, mem_addr3, mem_din3, mem_dout3;
   logic [3:0]  mem_be3;

   logic [31:0] mem  [0:MEMW-1];
   logic [31:0] mem3 [0:31];

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];
   vec_t sb_q[$];

   ls_unit #(.MEM_WORDS(MEMW), .ACCESS_LAT(1)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
      .baddr(baddr), .wdata(wdata), .ready(ready), .done(done), .err(err),
      .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   ls_unit #(.MEM_WORDS(MEMW), .ACCESS_LAT(3)) dut3 (
      .clk(clk), .rst(rst3), .req(req3), .we(we), .size(size), .sext(sext),
      .baddr(baddr), .wdata(wdata), .ready(ready3), .done(done3), .err(err3),
      .rdata(rdata3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_be(mem_be3),
      .mem_din(mem_din3), .mem_dout(mem_dout3)
   );

   // Memory places the low byte/half of din into the lanes selected by be.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            if (be == 4'b1111)                        r[8*b +: 8] = din[8*b +: 8];
            else if (be == 4'b0011 || be == 4'b1100)  r[8*b +: 8] = din[8*(b%2) +: 8];
            else                                      r[8*b +: 8] = din[7:0];
         end
      end
      return r;
   endfunction

   assign mem_dout  = (mem_addr < 32'(MEMW)) ? mem[mem_addr[12:0]] : 32'h0;
   assign mem_dout3 = (mem_addr3 < 32'd32) ? mem3[mem_addr3[4:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_we && mem_addr < 32'(MEMW))
         mem[mem_addr[12:0]] <= merge(mem[mem_addr[12:0]], mem_din, mem_be);
      if (mem_we3 && mem_addr3 < 32'd32)
         mem3[mem_addr3[4:0]] <= merge(mem3[mem_addr3[4:0]], mem_din3, mem_be3);
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input string name, input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d, input logic e,
                          input logic [31:0] rd, input logic [3:0] be, input logic [31:0] wa);
      vec_t v;
      v.name = name; v.we = w; v.size = sz; v.sext = sx; v.baddr = a; v.wdata = d;
      v.exp_err = e; v.exp_rdata = rd; v.exp_be = be; v.exp_addr = wa;
      tbl.push_back(v);
   endtask

   // One request on the ACCESS_LAT=1 unit; observations are compared when done appears.
   task automatic apply_stimulus(input vec_t v);
      vec_t        exp;
      logic [3:0]  seen_be;
      logic [31:0] seen_addr, seen_din;
      int          we_cnt, lat;
      bit          got;
      seen_be = 4'b0; seen_addr = 32'h0; seen_din = 32'h0; we_cnt = 0; lat = 0; got = 0;
      @(negedge clk);
      check_output({v.name, ".ready"}, 32'(ready), 32'd1);
      we = v.we; size = v.size; sext = v.sext; baddr = v.baddr; wdata = v.wdata; req = 1'b1;
      sb_q.push_back(v);
      for (int c = 1; c <= 20 && !got; c++) begin
         @(negedge clk);
         req = 1'b0;
         if (mem_be != 4'b0) begin
            seen_be = mem_be; seen_addr = mem_addr;
         end
         if (mem_we) begin
            we_cnt++; seen_din = mem_din;
         end
         if (done) begin
            got = 1; lat = c;
         end
      end
      exp = sb_q.pop_front();
      if (!got) begin
         checks++; errors++;
         $display("[TB] FAIL %s.timeout: got no done, expected done within 20 cycles", exp.name);
      end else begin
         check_output({exp.name, ".err"},     32'(err), 32'(exp.exp_err));
         check_output({exp.name, ".rdata"},   rdata, exp.exp_rdata);
         check_output({exp.name, ".latency"}, 32'(lat), exp.exp_err ? 32'd1 : 32'd2);
         check_output({exp.name, ".be"},      32'(seen_be), 32'(exp.exp_be));
         check_output({exp.name, ".we_pulses"}, 32'(we_cnt), 32'(exp.we && !exp.exp_err));
         if (!exp.exp_err) check_output({exp.name, ".addr"}, seen_addr, exp.exp_addr);
         if (exp.we && !exp.exp_err) check_output({exp.name, ".din"}, seen_din, exp.wdata);
      end
   endtask

   logic        trap_en;
   logic [31:0] r8, r14, r15, m17;
   logic [3:0]  be8, be14;
   int          done_cnt, we3_cnt, lat3;

   initial begin
`ifdef LS_MISALIGN_TRAP_EN
      trap_en = 1'b1; r8 = 32'h00001234; be8 = 4'b0000;
      r14 = 32'h00000000; be14 = 4'b0000; r15 = 32'h000000A5; m17 = 32'h000000A5;
`else
      trap_en = 1'b0; r8 = 32'h1234BEEF; be8 = 4'b1111;
      r14 = 32'h00000000; be14 = 4'b0011; r15 = 32'h00008001; m17 = 32'h00008001;
`endif
      for (int i = 0; i < MEMW; i++) mem[i] = 32'h0;
      for (int i = 0; i < 32; i++) mem3[i] = 32'h0;
      mem3[16] = 32'hCAFEF00D;

      rst = 1'b0; rst3 = 1'b0; req = 1'b0; req3 = 1'b0;
      we = 1'b0; size = 2'b00; sext = 1'b0; baddr = 32'h0; wdata = 32'h0;
      repeat (2) @(negedge clk);
      check_output("reset.ready",    32'(ready), 32'd1);
      check_output("reset.done",     32'(done), 32'd0);
      check_output("reset.err",      32'(err), 32'd0);
      check_output("reset.rdata",    rdata, 32'd0);
      check_output("reset.mem_we",   32'(mem_we), 32'd0);
      check_output("reset.mem_addr", mem_addr, 32'd0);
      check_output("reset.mem_be",   32'(mem_be), 32'd0);
      check_output("reset.mem_din",  mem_din, 32'd0);
      rst = 1'b1; rst3 = 1'b1;

      add_vec("st_word",   1, 2'b10, 0, 32'h40, 32'hDEADBEEF, 0, 32'h0,        4'b1111, 32'h10);
      add_vec("ld_word",   0, 2'b10, 0, 32'h40, 32'h0,        0, 32'hDEADBEEF, 4'b1111, 32'h10);
      add_vec("ld_b43_s",  0, 2'b00, 1, 32'h43, 32'h0,        0, 32'hFFFFFFDE, 4'b1000, 32'h10);
      add_vec("ld_b41_z",  0, 2'b00, 0, 32'h41, 32'h0,        0, 32'h000000BE, 4'b0010, 32'h10);
      add_vec("st_h42",    1, 2'b01, 0, 32'h42, 32'h00001234, 0, 32'h000000BE, 4'b1100, 32'h10);
      add_vec("ld_h40_s",  0, 2'b01, 1, 32'h40, 32'h0,        0, 32'hFFFFBEEF, 4'b0011, 32'h10);
      add_vec("ld_h42_z",  0, 2'b01, 0, 32'h42, 32'h0,        0, 32'h00001234, 4'b1100, 32'h10);
      add_vec("ld_w41",    0, 2'b10, 0, 32'h41, 32'h0,  trap_en, r8,           be8,     32'h10);
      add_vec("st_oor",    1, 2'b10, 0, 32'(4*MEMW), 32'h55, 1, r8,           4'b0000, 32'h0);
      add_vec("ld_sz11",   0, 2'b11, 0, 32'h40, 32'h0,        1, r8,           4'b0000, 32'h0);
      add_vec("st_b44",    1, 2'b00, 0, 32'h44, 32'h000000A5, 0, r8,           4'b0001, 32'h11);
      add_vec("ld_b44_s",  0, 2'b00, 1, 32'h44, 32'h0,        0, 32'hFFFFFFA5, 4'b0001, 32'h11);
      add_vec("ld_lastw",  0, 2'b10, 0, 32'(4*(MEMW-1)), 32'h0, 0, 32'h0,     4'b1111, 32'(MEMW-1));
      add_vec("st_h45",    1, 2'b01, 0, 32'h45, 32'hFFFF8001, trap_en, r14,    be14,    32'h11);
      add_vec("ld_w44",    0, 2'b10, 0, 32'h44, 32'h0,        0, r15,          4'b1111, 32'h11);
      for (int i = 0; i < tbl.size(); i++) apply_stimulus(tbl[i]);

      check_output("mem.word10", mem[16], 32'h1234BEEF);
      check_output("mem.word11", mem[17], m17);

      // A request held through ACCESS must not relatch the (now invalid) size.
      @(negedge clk);
      we = 1'b0; size = 2'b10; sext = 1'b0; baddr = 32'h40; req = 1'b1;
      done_cnt = 0;
      @(negedge clk);
      size = 2'b11;
      @(negedge clk);
      req = 1'b0;
      if (done) begin
         done_cnt++;
         check_output("busy.err",   32'(err), 32'd0);
         check_output("busy.rdata", rdata, 32'h1234BEEF);
      end
      repeat (4) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check_output("busy.done_count", 32'(done_cnt), 32'd1);

      // ACCESS_LAT=3: full load latency, then a store cut short by reset.
      @(negedge clk);
      we = 1'b0; size = 2'b10; baddr = 32'h40; req3 = 1'b1; lat3 = 0;
      for (int c = 1; c <= 20 && lat3 == 0; c++) begin
         @(negedge clk);
         req3 = 1'b0;
         if (done3) lat3 = c;
      end
      check_output("lat3.latency", 32'(lat3), 32'd4);
      check_output("lat3.rdata",   rdata3, 32'hCAFEF00D);

      @(negedge clk);
      we = 1'b1; size = 2'b10; baddr = 32'h40; wdata = 32'h11111111; req3 = 1'b1; we3_cnt = 0;
      @(posedge clk);
      @(negedge clk);
      req3 = 1'b0;
      if (mem_we3) we3_cnt++;
      @(posedge clk);
      #2 rst3 = 1'b0;
      #1 check_output("rst3.mem_we_now", 32'(mem_we3), 32'd0);
      repeat (3) begin
         @(negedge clk);
         if (mem_we3) we3_cnt++;
      end
      rst3 = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (mem_we3) we3_cnt++;
      end
      check_output("rst3.we_pulses", 32'(we3_cnt), 32'd0);
      check_output("rst3.mem_word",  mem3[16], 32'hCAFEF00D);
      check_output("rst3.ready",     32'(ready3), 32'd1);
      check_output("rst3.done",      32'(done3), 32'd0);
      check_output("rst3.rdata",     rdata3, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
